mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 32-bit memory port between instruction fetch (IF) and load/store (D).
//  Sits between the fetch/LSU stages and memory; drives the select of the 32-bit 2:1 address/wdata mux.
//  Registers each granted request, holds it until the memory acknowledges, then returns read data with a valid pulse.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  STARVE_MAX  4   consecutive D grants with IF waiting before IF is forced to win
//  TIMEOUT     15  BUSY cycles without mem_ready before abort (only with MEM_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  if_req     in   1       fetch request; held until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       1-cycle pulse: fetch request accepted
//  if_valid   out  1       1-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction
//  d_req      in   1       load/store request; held until d_gnt
//  d_we       in   1       1 = store
//  d_be       in   4       byte enables
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       1-cycle pulse: data request accepted
//  d_valid    out  1       1-cycle pulse: access complete, d_rdata valid for loads
//  d_rdata    out  DATA_W  load data; 0 for stores
//  mem_req    out  1       memory request, held high while BUSY
//  mem_we     out  1       registered d_we; 0 for fetch
//  mem_be     out  4       registered byte enables; 4'hF for fetch
//  mem_addr   out  ADDR_W  registered address
//  mem_wdata  out  DATA_W  registered store data; 0 for fetch
//  mem_rdata  in   DATA_W  memory read data, sampled with mem_ready
//  mem_ready  in   1       memory completion, sampled only while mem_req=1
//  mux_sel    out  1       0 = fetch source, 1 = data source; registered
//  err        out  1       1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except mem_be=0; starve_cnt=0.
//  Async reset mid-transaction drops mem_req immediately; the in-flight access is lost, with no valid pulse.
//  FSM IDLE -> BUSY_IF | BUSY_D -> IDLE.
//  IDLE winner selection:
//   - If only one request is pending, that requester wins.
//   - If both are pending, D wins unless starve_cnt == STARVE_MAX, in which case IF wins.
//  At the grant edge:
//   - Capture addr, we, be and wdata into mem_* registers; set mux_sel; mem_req <= 1.
//   - Pulse the winner's gnt in the next cycle.
//  starve_cnt:
//   - +1 on each D grant while if_req=1.
//   - Cleared on any IF grant, or when if_req=0 in IDLE.
//   - Saturates at STARVE_MAX.
//  BUSY with mem_ready=1 at an edge:
//   - Register mem_rdata into if_rdata or d_rdata (d_rdata=0 for stores).
//   - Pulse the owner's valid next cycle; mem_req <= 0; state <= IDLE.
//  Latency: req sampled in cycle N -> gnt and mem_req in N+1.
//   - Zero-wait memory (ready in N+1) -> valid in N+2.
//   - Next arbitration in N+2; best throughput is one access per 2 cycles.
//  Requests arriving while BUSY wait. A req dropped before gnt is ignored. Data outputs hold their last value outside valid.
//  mux_sel holds its last value in IDLE.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//   - A BUSY cycle counter is cleared on grant.
//   - On reaching TIMEOUT without mem_ready: mem_req <= 0, owner's valid pulses with rdata=0, err pulses, state <= IDLE.
//  Undefined: no counter, BUSY waits indefinitely, err tied 0.
// STRUCTURE
//  Package mem_arb_pkg holds:
//   - state enum {IDLE, BUSY_IF, BUSY_D}
//   - MUX_SEL_IF=1'b0, MUX_SEL_D=1'b1
//   - FETCH_BE=4'hF
//  Sub-module mem_arb_timer: timeout counter, instantiated only under MEM_ARB_TIMEOUT_EN.
// TESTING
//  1 IF read: if_req, if_addr=0x100, mem_ready in cycle after gnt, mem_rdata=0x00000013 -> if_gnt N+1, mem_addr=0x100, mem_be=F, if_valid N+2, if_rdata=0x13.
//  2 Simultaneous req, store: d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=3 -> d_gnt first, mux_sel=1, mem_we=1, d_rdata=0; IF granted next.
//  3 Starvation: d_req and if_req held high for 6 accesses -> 4 D grants, then IF grant; starve_cnt back to 0.
//  4 Wait states: mem_ready delayed 5 cycles -> mem_req and mem_addr stable for 5 cycles, single valid pulse, no extra gnt.
//  5 rst asserted mid BUSY_D -> mem_req, gnt and valid low asynchronously; after release IDLE, fresh IF req served normally.
//  6 With MEM_ARB_TIMEOUT_EN, mem_ready never -> err and valid pulse after 15 BUSY cycles, rdata=0, back to IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_e;

    localparam logic       MUX_SEL_IF = 1'b0;
    localparam logic       MUX_SEL_D  = 1'b1;
    localparam logic [3:0] FETCH_BE   = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Requester and memory side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_timer.sv
// Counts BUSY cycles without mem_ready; flags the cycle in which the access must be aborted.
module mem_arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic busy_i,
    input  logic ready_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (busy_i && !ready_i && cnt_q != CW'(TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // The TIMEOUT-th BUSY cycle is the last one; a late ready still wins.
    assign expired_o = busy_i && !ready_i && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, with D priority and IF anti-starvation.
// Optional busy timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic                mux_sel_o,
    output logic                err_o
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [SW-1:0]     starve_q;
    logic              grant_if, grant_d, done, timeout_hit, abort;

    logic              if_gnt_q, d_gnt_q, if_valid_q, d_valid_q, err_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              mem_req_q, mem_we_q, mux_sel_q;
    logic [3:0]        mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_if)     state_d = BUSY_IF;
                else if (grant_d) state_d = BUSY_D;
            end
            BUSY_IF, BUSY_D: begin
                if (done || abort) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // IF wins a tie only once D has been granted STARVE_MAX times in a row over it.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        if (state_q == IDLE) begin
            grant_if = bus.if_req && (!bus.d_req || starve_q == SW'(STARVE_MAX));
            grant_d  = bus.d_req && !grant_if;
        end else begin
            done  = bus.mem_ready;
            abort = timeout_hit;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .start_i   (grant_if || grant_d),
        .busy_i    (state_q != IDLE),
        .ready_i   (bus.mem_ready),
        .expired_o (timeout_hit)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q    <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mux_sel_q   <= 1'b0;
        end else begin
            if_gnt_q   <= grant_if;
            d_gnt_q    <= grant_d;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= abort;

            if (grant_if) begin
                starve_q <= '0;
            end else if (grant_d && bus.if_req) begin
                if (starve_q != SW'(STARVE_MAX)) starve_q <= starve_q + 1'b1;
            end else if (state_q == IDLE && !bus.if_req) begin
                starve_q <= '0;
            end

            if (grant_if || grant_d) begin
                mem_req_q   <= 1'b1;
                mux_sel_q   <= grant_d ? MUX_SEL_D : MUX_SEL_IF;
                mem_addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
                mem_we_q    <= grant_d && bus.d_we;
                mem_be_q    <= grant_d ? bus.d_be : FETCH_BE;
                mem_wdata_q <= grant_d ? bus.d_wdata : '0;
            end

            // An aborted access returns zero data.
            if (done || abort) begin
                mem_req_q <= 1'b0;
                if (state_q == BUSY_IF) begin
                    if_valid_q <= 1'b1;
                    if_rdata_q <= done ? bus.mem_rdata : '0;
                end else begin
                    d_valid_q <= 1'b1;
                    d_rdata_q <= (done && !mem_we_q) ? bus.mem_rdata : '0;
                end
            end
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign mux_sel_o     = mux_sel_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level arbitration model.
module tb_mem_port_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 15;

    logic clk = 1'b0;
    logic rst;
    logic mux_sel, err;

    int n_vec = 0;
    int n_miscmp = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mux_sel_o (mux_sel),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    // Model state: pending requests and how many D wins IF has sat through.
    bit          if_pend, d_pend;
    logic [31:0] m_if_addr, m_d_addr, m_d_wdata;
    logic [3:0]  m_d_be;
    bit          m_d_we;
    int          m_starve;
    int          n_d_grants, n_if_grants;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic raise_if(input logic [31:0] addr);
        if_pend = 1'b1; m_if_addr = addr;
        bus.if_req = 1'b1; bus.if_addr = addr;
    endtask

    task automatic raise_d(input bit we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
        d_pend = 1'b1; m_d_we = we; m_d_be = be; m_d_addr = addr; m_d_wdata = wdata;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wdata;
    endtask

    // Called at a negedge while the arbiter is idle with at least one request pending.
    task automatic do_round(input int waits, input logic [31:0] rd);
        bit          win_d;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0]  e_be;
        bit          e_we;
        win_d = d_pend && (!if_pend || m_starve != STARVE_MAX);
        if (win_d) m_starve = if_pend ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
        else       m_starve = 0;
        if (win_d) n_d_grants++; else n_if_grants++;
        e_addr  = win_d ? m_d_addr : m_if_addr;
        e_be    = win_d ? m_d_be : 4'hF;
        e_we    = win_d && m_d_we;
        e_wdata = win_d ? m_d_wdata : 32'h0;
        e_rdata = (win_d && m_d_we) ? 32'h0 : rd;

        @(posedge clk); @(negedge clk);
        check_val("if_gnt", bus.if_gnt, !win_d);
        check_val("d_gnt", bus.d_gnt, win_d);
        check_val("mem_req", bus.mem_req, 1);
        check_val("mem_addr", bus.mem_addr, e_addr);
        check_val("mem_be", bus.mem_be, e_be);
        check_val("mem_we", bus.mem_we, e_we);
        check_val("mem_wdata", bus.mem_wdata, e_wdata);
        check_val("mux_sel", mux_sel, win_d);
        check_val("valid_idle", {bus.if_valid, bus.d_valid}, 0);
        if (win_d) begin d_pend = 1'b0; bus.d_req = 1'b0; end
        else       begin if_pend = 1'b0; bus.if_req = 1'b0; end
        bus.mem_rdata = (waits == 0) ? rd : $urandom;
        bus.mem_ready = (waits == 0);

        for (int i = 0; i < waits; i++) begin
            @(posedge clk); @(negedge clk);
            check_val("wait_req", bus.mem_req, 1);
            check_val("wait_addr", bus.mem_addr, e_addr);
            check_val("wait_quiet", {bus.if_gnt, bus.d_gnt, bus.if_valid, bus.d_valid}, 0);
            if (i == waits - 1) begin bus.mem_rdata = rd; bus.mem_ready = 1'b1; end
        end

        @(posedge clk); @(negedge clk);
        bus.mem_ready = 1'b0;
        check_val("if_valid", bus.if_valid, !win_d);
        check_val("d_valid", bus.d_valid, win_d);
        check_val("rdata", win_d ? bus.d_rdata : bus.if_rdata, e_rdata);
        check_val("req_drop", bus.mem_req, 0);
        check_val("err", err, 0);
    endtask

    task automatic model_reset();
        if_pend = 0; d_pend = 0; m_starve = 0;
        bus.if_req = 0; bus.d_req = 0; bus.mem_ready = 0;
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_be = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_outs", {bus.mem_req, bus.if_gnt, bus.d_gnt, bus.if_valid, bus.d_valid, err, mux_sel}, 0);
        check_val("rst_be", bus.mem_be, 0);
        check_val("rst_addr", bus.mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single fetch, zero-wait memory.
        raise_if(32'h100);
        do_round(0, 32'h0000_0013);

        // Simultaneous requests: the store goes first, then the fetch.
        raise_if(32'h104);
        raise_d(1'b1, 4'h3, 32'h2000, 32'hDEAD_BEEF);
        do_round(0, 32'h1234_5678);
        do_round(0, 32'h0000_0093);

        // Both requesters kept busy: four D grants, then IF.
        n_d_grants = 0; n_if_grants = 0;
        for (int k = 0; k < 6; k++) begin
            if (!if_pend) raise_if(32'h200 + 32'(k * 4));
            if (!d_pend) raise_d(1'b0, 4'hF, 32'h3000 + 32'(k * 4), 32'h0);
            do_round(0, $urandom);
            if (k == 3) check_val("starve_d4", n_d_grants, 4);
            if (k == 4) check_val("starve_if", n_if_grants, 1);
        end
        do_round(0, $urandom);

        // Five wait states.
        raise_d(1'b0, 4'hC, 32'h4000, 32'h0);
        do_round(5, 32'hCAFE_F00D);

        // Reset in the middle of a data access.
        raise_d(1'b1, 4'hF, 32'h5000, 32'h5555_AAAA);
        @(posedge clk); @(negedge clk);
        check_val("busy_d", bus.d_gnt, 1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_quiet", {bus.mem_req, bus.d_gnt, bus.d_valid, bus.if_gnt}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst", {bus.mem_req, bus.d_valid, bus.if_valid}, 0);
        raise_if(32'h600);
        do_round(1, 32'h0000_0073);

`ifdef MEM_ARB_TIMEOUT_EN
        raise_if(32'h700);
        m_starve = 0;
        @(posedge clk); @(negedge clk);
        check_val("to_gnt", bus.if_gnt, 1);
        if_pend = 0; bus.if_req = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            @(posedge clk); @(negedge clk);
            check_val("to_wait", {bus.mem_req, err, bus.if_valid}, 3'b100);
        end
        @(posedge clk); @(negedge clk);
        check_val("to_err", {err, bus.if_valid, bus.mem_req}, 3'b110);
        check_val("to_rdata", bus.if_rdata, 0);
`endif

        // Random traffic.
        for (int r = 0; r < 80; r++) begin
            if (!if_pend && !d_pend && $urandom_range(0, 7) == 0) begin
                m_starve = 0;
                @(posedge clk); @(negedge clk);
                check_val("idle_quiet", {bus.mem_req, bus.if_gnt, bus.d_gnt}, 0);
            end
            if (!if_pend && $urandom_range(0, 2) != 0) raise_if($urandom);
            if (!d_pend && $urandom_range(0, 2) != 0)
                raise_d(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, $urandom);
            if (!if_pend && !d_pend) raise_if($urandom);
            do_round($urandom_range(0, 3), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
